// File: rtl/stepper_pkg.sv
// Shared definitions for the two-axis stepper move sequencer: FSM encoding
// and default timing constants.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam int DEF_PULSE_WIDTH = 1000;
    localparam int DEF_DIR_SETUP   = 50;
    localparam int DEF_MIN_PERIOD  = 2 * DEF_PULSE_WIDTH;

    // Shortest legal step period: the gap must be at least as long as the pulse.
    function automatic int min_period(input int pulse_width);
        return 2 * pulse_width;
    endfunction

endpackage

// File: rtl/step_pulse_timer.sv
// Down-counter shared by the SETUP, PULSE and GAP phases. Load N-1 to time an
// N-cycle phase; expire is high during the phase's last cycle.
module step_pulse_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, count down, or rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/xy_move_sequencer.sv
// Two-axis move sequencer: accepts relative moves, runs Bresenham interpolation
// and drives STEP/DIR pins with fixed-width pulses while tracking position.
module xy_move_sequencer
    import stepper_pkg::*;
#(
    parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
    parameter int DIR_SETUP   = DEF_DIR_SETUP,
    parameter int DELTA_W     = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DELTA_W-1:0] cmd_dx,
    input  logic [DELTA_W-1:0] cmd_dy,
    input  logic [CNT_W-1:0]   cmd_period,
    input  logic               abort,
    output logic               step_x,
    output logic               step_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [CNT_W-1:0]   pos_x,
    output logic [CNT_W-1:0]   pos_y
);

    localparam int               ERR_W      = DELTA_W + 2;
    localparam logic [CNT_W-1:0] MIN_PER    = CNT_W'(min_period(PULSE_WIDTH));
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_SUB    = CNT_W'(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0] POS_INC    = CNT_W'(1);
    localparam logic [CNT_W-1:0] POS_DEC    = {CNT_W{1'b1}};

    seq_state_e         state_q, state_d;
    logic [DELTA_W-1:0] major_q, major_d, minor_q, minor_d;
    logic [DELTA_W-1:0] steps_left_q, steps_left_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic               x_major_q, x_major_d;
    logic               abort_pend_q, abort_pend_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               step_x_q, step_x_d, step_y_q, step_y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic               busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic [CNT_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;

    logic               accept_s;
    logic [DELTA_W-1:0] ax_s, ay_s, major_s, minor_s;
    logic               x_major_s;
    logic [ERR_W-1:0]   err_sub_s, err_next_s;
    logic               minor_step_s, x_step_s, y_step_s;
    logic               go_pulse_s, t_load_s, t_expire_s;
    logic [CNT_W-1:0]   t_val_s;

    // |-2^(DELTA_W-1)| still fits because ax/ay are treated as unsigned.
    assign accept_s  = cmd_valid & cmd_ready_q;
    assign ax_s      = cmd_dx[DELTA_W-1] ? (DELTA_W'(0) - cmd_dx) : cmd_dx;
    assign ay_s      = cmd_dy[DELTA_W-1] ? (DELTA_W'(0) - cmd_dy) : cmd_dy;
    assign x_major_s = (ax_s >= ay_s);
    assign major_s   = x_major_s ? ax_s : ay_s;
    assign minor_s   = x_major_s ? ay_s : ax_s;

    assign err_sub_s    = err_q - {2'b00, minor_q};
    assign minor_step_s = err_sub_s[ERR_W-1];
    assign err_next_s   = minor_step_s ? (err_sub_s + {2'b00, major_q}) : err_sub_s;
    assign x_step_s     = x_major_q | minor_step_s;
    assign y_step_s     = ~x_major_q | minor_step_s;

    step_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load_s),
        .load_val (t_val_s),
        .expire   (t_expire_s)
    );

    // Sequencer FSM, Bresenham step and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        major_d      = major_q;
        minor_d      = minor_q;
        steps_left_d = steps_left_q;
        err_d        = err_q;
        per_d        = per_q;
        x_major_d    = x_major_q;
        abort_pend_d = 1'b0;
        step_x_d     = 1'b0;
        step_y_d     = 1'b0;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        aborted_d    = 1'b0;
        go_pulse_s   = 1'b0;
        t_load_s     = 1'b0;
        t_val_s      = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    dir_x_d      = ~cmd_dx[DELTA_W-1];
                    dir_y_d      = ~cmd_dy[DELTA_W-1];
                    per_d        = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;
                    major_d      = major_s;
                    minor_d      = minor_s;
                    x_major_d    = x_major_s;
                    err_d        = {2'b00, major_s >> 1};
                    steps_left_d = major_s;
                    if (major_s == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SETUP;
                        t_load_s = 1'b1;
                        t_val_s  = SETUP_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (t_expire_s) begin
                    go_pulse_s = 1'b1;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_PULSE: begin
                // An abort during a pulse waits for the pulse to finish.
                abort_pend_d = abort_pend_q | abort;
                if (t_expire_s) begin
                    if (abort_pend_q | abort) begin
                        state_d   = ST_DONE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d  = ST_GAP;
                        t_load_s = 1'b1;
                        t_val_s  = per_q - GAP_SUB;
                    end
                end else begin
                    step_x_d = step_x_q;
                    step_y_d = step_y_q;
                end
            end
            ST_GAP: begin
                if (t_expire_s && (steps_left_q == '0)) begin
                    state_d = ST_DONE;
                end else if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (t_expire_s) begin
                    go_pulse_s = 1'b1;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_pulse_s) begin
            state_d      = ST_PULSE;
            t_load_s     = 1'b1;
            t_val_s      = PULSE_LOAD;
            err_d        = err_next_s;
            steps_left_d = steps_left_q - DELTA_W'(1);
            step_x_d     = x_step_s;
            step_y_d     = y_step_s;
            if (x_step_s) begin
                pos_x_d = pos_x_q + (dir_x_q ? POS_INC : POS_DEC);
            end else begin
                pos_x_d = pos_x_q;
            end
            if (y_step_s) begin
                pos_y_d = pos_y_q + (dir_y_q ? POS_INC : POS_DEC);
            end else begin
                pos_y_d = pos_y_q;
            end
        end else begin
            steps_left_d = steps_left_d;
        end

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers; reset clears everything including position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            major_q      <= '0;
            minor_q      <= '0;
            steps_left_q <= '0;
            err_q        <= '0;
            per_q        <= '0;
            x_major_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            cmd_ready_q  <= 1'b0;
            step_x_q     <= 1'b0;
            step_y_q     <= 1'b0;
            dir_x_q      <= 1'b0;
            dir_y_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            major_q      <= major_d;
            minor_q      <= minor_d;
            steps_left_q <= steps_left_d;
            err_q        <= err_d;
            per_q        <= per_d;
            x_major_q    <= x_major_d;
            abort_pend_q <= abort_pend_d;
            cmd_ready_q  <= cmd_ready_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign step_x    = step_x_q;
    assign step_y    = step_y_q;
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;

endmodule

// File: tb/tb_xy_move_sequencer.sv
// Directed bench for xy_move_sequencer with PULSE_WIDTH=4, DIR_SETUP=2.
// Time "rel" counts cycles after the accepting edge; rel=1 is the first one.
module tb_xy_move_sequencer;

    localparam int PW = 4;
    localparam int DS = 2;
    localparam int DW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_dx;
    logic [DW-1:0] cmd_dy;
    logic [CW-1:0] cmd_period;
    logic          abort;
    logic          step_x, step_y, dir_x, dir_y, busy, done, aborted;
    logic [CW-1:0] pos_x, pos_y;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int dx; int dy; int per; int exp_per;
        int nx; int ny; int first; int mask; int done_rel;
        int dir_x; int dir_y; int pos_x; int pos_y;
    } vec_t;

    typedef struct {
        int dir_x; int dir_y; int nx; int ny; int first; int mask;
        int sp_err; int wid_err; int trk_err; int done_rel; int aborted;
        int busy_cyc; int pos_x; int pos_y;
    } res_t;

    xy_move_sequencer #(
        .PULSE_WIDTH (PW),
        .DIR_SETUP   (DS),
        .DELTA_W     (DW),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dx     (cmd_dx),
        .cmd_dy     (cmd_dy),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step_x     (step_x),
        .step_y     (step_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pos_x      (pos_x),
        .pos_y      (pos_y)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for cmd_ready, presents one command, returns at rel=1.
    task automatic send(input int dx, input int dy, input int per);
        int w;
        w = 0;
        while (!cmd_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("send_ready", int'(cmd_ready), 1);
        cmd_dx     = DW'(dx);
        cmd_dy     = DW'(dy);
        cmd_period = CW'(per);
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    // Observes one move until done (bounded); optionally raises abort for one cycle.
    task automatic watch(input int dx, input int dy, input int exp_per, input int abort_rel,
                         input int start_x, input int start_y, output res_t r);
        logic px_prev, py_prev, rx, ry;
        int   runx, runy, last, events, mx, my;
        r = '{default: 0};
        px_prev = 1'b0; py_prev = 1'b0;
        runx = 0; runy = 0; last = 0; events = 0;
        mx = start_x; my = start_y;
        r.dir_x = int'(dir_x);
        r.dir_y = int'(dir_y);
        for (int rel = 1; rel <= 600; rel++) begin
            abort = (rel == abort_rel);
            rx = step_x & ~px_prev;
            ry = step_y & ~py_prev;
            if (rx) begin mx += (dx >= 0) ? 1 : -1; r.nx++; end
            if (ry) begin my += (dy >= 0) ? 1 : -1; r.ny++; end
            if (rx | ry) begin
                if (events == 0) r.first = rel;
                else if (rel - last != exp_per) r.sp_err++;
                if (rx & ry) r.mask |= (1 << events);
                events++;
                last = rel;
            end
            if (step_x) runx++;
            else begin if (px_prev && runx != PW) r.wid_err++; runx = 0; end
            if (step_y) runy++;
            else begin if (py_prev && runy != PW) r.wid_err++; runy = 0; end
            if ($signed(pos_x) != mx || $signed(pos_y) != my) r.trk_err++;
            if (busy) r.busy_cyc++;
            px_prev = step_x;
            py_prev = step_y;
            if (done) begin
                r.done_rel = rel;
                r.aborted  = int'(aborted);
                r.pos_x    = $signed(pos_x);
                r.pos_y    = $signed(pos_y);
                break;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic report(input int i, input vec_t v, input res_t r);
        chk($sformatf("v%0d_dir_x", i),    r.dir_x,    v.dir_x);
        chk($sformatf("v%0d_dir_y", i),    r.dir_y,    v.dir_y);
        chk($sformatf("v%0d_nx", i),       r.nx,       v.nx);
        chk($sformatf("v%0d_ny", i),       r.ny,       v.ny);
        chk($sformatf("v%0d_first", i),    r.first,    v.first);
        chk($sformatf("v%0d_both_mask", i), r.mask,    v.mask);
        chk($sformatf("v%0d_spacing", i),  r.sp_err,   0);
        chk($sformatf("v%0d_width", i),    r.wid_err,  0);
        chk($sformatf("v%0d_pos_track", i), r.trk_err, 0);
        chk($sformatf("v%0d_done_rel", i), r.done_rel, v.done_rel);
        chk($sformatf("v%0d_aborted", i),  r.aborted,  0);
        chk($sformatf("v%0d_busy_cyc", i), r.busy_cyc, v.done_rel);
        chk($sformatf("v%0d_pos_x", i),    r.pos_x,    v.pos_x);
        chk($sformatf("v%0d_pos_y", i),    r.pos_y,    v.pos_y);
    endtask

    vec_t vecs[6];
    res_t res;
    int   ex_x, ex_y, hd;

    initial begin
        // dx, dy, period, edge spacing, nx, ny, first edge, both-axis mask, done rel,
        // dir_x, dir_y, absolute pos after the move (positions accumulate)
        vecs[0] = '{ 5,  2, 10, 10, 5, 2, 3, 5'b01010, 53, 1, 1, 5,  2};
        vecs[1] = '{-3,  0, 20, 20, 3, 0, 3, 0,        63, 0, 1, 2,  2};
        vecs[2] = '{ 0, -4,  3,  8, 0, 4, 3, 0,        35, 1, 0, 2, -2};
        vecs[3] = '{ 0,  0, 10, 10, 0, 0, 0, 0,         1, 1, 1, 2, -2};
        vecs[4] = '{ 3, -3,  8,  8, 3, 3, 3, 3'b111,   27, 1, 0, 5, -5};
        vecs[5] = '{-2,  5,  8,  8, 2, 5, 3, 5'b01010, 43, 0, 1, 3,  0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_dx = '0; cmd_dy = '0; cmd_period = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({step_x, step_y, dir_x, dir_y, busy, done, aborted, cmd_ready}), 0);
        chk("reset_pos_x", $signed(pos_x), 0);
        chk("reset_pos_y", $signed(pos_y), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", int'(cmd_ready), 1);
        chk("post_reset_busy", int'(busy), 0);

        ex_x = 0; ex_y = 0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].dx, vecs[i].dy, vecs[i].per);
            watch(vecs[i].dx, vecs[i].dy, vecs[i].exp_per, 0, ex_x, ex_y, res);
            report(i, vecs[i], res);
            ex_x = vecs[i].pos_x;
            ex_y = vecs[i].pos_y;
        end

        // cmd_valid held high for the whole move must not start a second move.
        send(2, 0, 8);
        cmd_dx = DW'(7); cmd_period = CW'(8); cmd_valid = 1'b1;
        hd = 0;
        for (int k = 1; k <= 200; k++) begin
            if (done) begin hd = k; break; end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("hold_done_rel", hd, 19);
        @(posedge clk); #1;
        chk("hold_idle_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        chk("hold_not_accepted", int'(busy), 0);
        chk("hold_pos_x", $signed(pos_x), 5);

        // Abort in the GAP after pulse #2.
        send(10, 0, 12);
        watch(10, 0, 12, 20, 5, 0, res);
        chk("gap_abort_nx", res.nx, 2);
        chk("gap_abort_done_rel", res.done_rel, 21);
        chk("gap_abort_aborted", res.aborted, 1);
        chk("gap_abort_pos_x", res.pos_x, 7);

        // Abort during pulse #3: pulse keeps its full width.
        send(10, 0, 12);
        watch(10, 0, 12, 28, 7, 0, res);
        chk("pulse_abort_nx", res.nx, 3);
        chk("pulse_abort_width", res.wid_err, 0);
        chk("pulse_abort_done_rel", res.done_rel, 31);
        chk("pulse_abort_aborted", res.aborted, 1);
        chk("pulse_abort_pos_x", res.pos_x, 10);

        // Abort in the final GAP cycle is ignored.
        send(1, 0, 8);
        watch(1, 0, 8, 10, 10, 0, res);
        chk("final_gap_abort_nx", res.nx, 1);
        chk("final_gap_abort_done_rel", res.done_rel, 11);
        chk("final_gap_abort_aborted", res.aborted, 0);
        chk("final_gap_abort_pos_x", res.pos_x, 11);

        // Reset in the middle of pulse #1.
        send(5, 0, 10);
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mid_step_high", int'(step_x), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_step_x", int'(step_x), 0);
        chk("rst_mid_pos_x", $signed(pos_x), 0);
        chk("rst_mid_pos_y", $signed(pos_y), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(cmd_ready), 0);
        chk("rst_mid_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", int'(cmd_ready), 1);
        send(2, 1, 8);
        watch(2, 1, 8, 0, 0, 0, res);
        chk("after_rst_nx", res.nx, 2);
        chk("after_rst_ny", res.ny, 1);
        chk("after_rst_mask", res.mask, 2);
        chk("after_rst_done_rel", res.done_rel, 19);
        chk("after_rst_pos_track", res.trk_err, 0);
        chk("after_rst_pos_x", res.pos_x, 2);
        chk("after_rst_pos_y", res.pos_y, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
